riscv_ex_mdu_ctrl: RTL

- Sequencing controller for the EX-stage multiply/divide unit (RV32M).
- Accepts one M-extension op from the EX stage via valid/ready and runs an iterative radix-2 shift-add multiplier or restoring divider over DATA_WIDTH cycles.
- Returns the result via valid/ready and holds the pipeline through in_ready and out_valid.
- Sits alongside the EX ALU. The EX stage routes OP opcode with inst[25]=1 here instead of to the ALU.

---
 rtl/riscv_ex_mdu_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/riscv_ex_mdu_ctrl.sv
// riscv_ex_mdu_ctrl: RV32M multiply/divide sequencer for the EX stage.
//   Accepts one op (funct3 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) on
//   in_valid/in_ready, iterates a radix-2 shift-add multiplier or restoring
//   divider for DATA_WIDTH cycles, then presents result on out_valid/out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/funct3/op_a/op_b request;
//   flush kills the current op; out_valid/out_ready/result response; busy = stall.
// Optional: define RISCV_MDU_FAST_MUL_EN for a single-cycle combinational
//   multiplier (multiply ops finish one cycle after accept; divides unchanged).
module riscv_ex_mdu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 is_div;
  logic [1:0]           op_sel;    // funct3[1:0] of the op in flight
  logic                 neg_res;   // product / quotient needs negation
  logic                 neg_rem;   // remainder takes the dividend's sign
  logic [W-1:0]         mcand;     // multiplicand magnitude, or divisor magnitude
  // Multiply: {partial-product high, multiplier shifting out / product low}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*W-1:0]       work;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // ---------------- accept-time decode ----------------
  logic         a_signed, b_signed, sign_a, sign_b;
  logic [W-1:0] mag_a, mag_b;
  logic         div_by_zero, div_ovf;
  logic [W-1:0] special_res;

  always_comb begin
    // MULHU, DIVU, REMU treat both operands as unsigned; MULHSU only rs2.
    a_signed = !((funct3 == 3'b011) || (funct3 == 3'b101) || (funct3 == 3'b111));
    b_signed = a_signed && (funct3 != 3'b010);
    sign_a   = a_signed && op_a[W-1];
    sign_b   = b_signed && op_b[W-1];
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;

    div_by_zero = funct3[2] && (op_b == '0);
    // Most-negative / -1 only overflows for the signed DIV and REM encodings.
    div_ovf     = funct3[2] && !funct3[0] && (op_a == {1'b1, {(W-1){1'b0}}}) &&
                  (op_b == '1);

    special_res = '0;
    if (div_by_zero) special_res = funct3[1] ? op_a : '1;
    else             special_res = funct3[1] ? '0 : op_a;
  end

`ifdef RISCV_MDU_FAST_MUL_EN
  logic [2*W-1:0] fast_a, fast_b, fast_prod;
  logic [W-1:0]   fast_res;

  always_comb begin
    // Sign-extend to 2W bits; the low 2W bits of the product are exact for
    // every signed/unsigned operand combination.
    fast_a    = {{W{sign_a}}, op_a};
    fast_b    = {{W{sign_b}}, op_b};
    fast_prod = fast_a * fast_b;
    fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
  end
`endif

  // ---------------- one iteration ----------------
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift, div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  logic [W-1:0]   final_res;

  always_comb begin
    // Add the multiplicand into the high half when the multiplier LSB is set,
    // then shift the whole (2W+1)-bit value right by one.
    mul_sum  = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    mul_next = {mul_sum, work[W-1:1]};

    // Restoring step: bring the next dividend bit into the partial remainder,
    // subtract the divisor if it fits, shift the quotient bit in at the LSB.
    div_shift = {work[2*W-1:W], work[W-1]};
    div_diff  = div_shift - {1'b0, mcand};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), work[W-2:0], div_ge};

    prod_fix = neg_res ? -mul_next : mul_next;
    quo_fix  = neg_res ? -div_next[W-1:0] : div_next[W-1:0];
    rem_fix  = neg_rem ? -div_next[2*W-1:W] : div_next[2*W-1:W];

    final_res = '0;
    if (is_div)              final_res = op_sel[1] ? rem_fix : quo_fix;
    else if (op_sel == 2'b00) final_res = prod_fix[W-1:0];
    else                     final_res = prod_fix[2*W-1:W];
  end

  // ---------------- sequencing ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      result  <= '0;
      is_div  <= 1'b0;
      op_sel  <= 2'b00;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      mcand   <= '0;
      work    <= '0;
    end else if (flush) begin
      // Flush beats accept and out_ready; result keeps its last value.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            is_div  <= funct3[2];
            op_sel  <= funct3[1:0];
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            cnt     <= '0;
            work    <= {{W{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            mcand   <= funct3[2] ? mag_b : mag_a;
            if (div_by_zero || div_ovf) begin
              result <= special_res;
              state  <= S_DONE;
            end
`ifdef RISCV_MDU_FAST_MUL_EN
            else if (!funct3[2]) begin
              result <= fast_res;
              state  <= S_DONE;
            end
`endif
            else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          work <= is_div ? div_next : mul_next;
          cnt  <= cnt + CNT_WIDTH'(1);
          if (cnt == LAST_ITER) begin
            result <= final_res;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
